// File: rtl/eater_pkg.sv
// Shared types and default widths for the program loader and its helpers.
package eater_pkg;

    localparam int DATA_W_DEF      = 8;
    localparam int ADDR_W_DEF      = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_CHECK = 3'd4
    } state_e;

endpackage

// File: rtl/pin_sync.sv
// Multi-flop synchronizer for a group of asynchronous pins.
module pin_sync #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_r [DEPTH];

    // Shift the pin values through DEPTH flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            stage_r[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/prog_loader.sv
// Pin-driven RAM programmer: halts the CPU, writes one word per strobe and verifies it by read-back.
module prog_loader
    import eater_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_mode,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              wr_strobe,
    input  logic              auto_inc,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              cpu_halt,
    output logic              busy,
    output logic              verify_err,
    output logic              overrun,
    output logic [ADDR_W:0]   write_count
);

    logic [2:0]          ctrl_sync_s;
    logic [ADDR_W-1:0]   addr_sync_s;
    logic [DATA_W-1:0]   data_sync_s;
    logic                prog_s;
    logic                strobe_s;
    logic                auto_s;
    logic                strobe_prev_r;
    logic [SYNC_STAGES:0] settle_r;
    logic                strobe_evt_s;
    logic [ADDR_W-1:0]   pointer_r;
    state_e              state_r;

    pin_sync #(.WIDTH(3), .DEPTH(SYNC_STAGES)) u_sync_ctrl (
        .clk(clk), .rst_n(rst_n), .d({prog_mode, wr_strobe, auto_inc}), .q(ctrl_sync_s)
    );
    pin_sync #(.WIDTH(ADDR_W), .DEPTH(SYNC_STAGES)) u_sync_addr (
        .clk(clk), .rst_n(rst_n), .d(addr_in), .q(addr_sync_s)
    );
    pin_sync #(.WIDTH(DATA_W), .DEPTH(SYNC_STAGES)) u_sync_data (
        .clk(clk), .rst_n(rst_n), .d(data_in), .q(data_sync_s)
    );

    assign prog_s   = ctrl_sync_s[2];
    assign strobe_s = ctrl_sync_s[1];
    assign auto_s   = ctrl_sync_s[0];

    // Edges only count once the synchronizer and history flop hold real pin values,
    // so a strobe held high across reset release is not mistaken for a new edge.
    assign strobe_evt_s = settle_r[SYNC_STAGES] & strobe_s & ~strobe_prev_r;

    // Strobe history and post-reset settle tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strobe_prev_r <= 1'b0;
            settle_r      <= {(SYNC_STAGES+1){1'b0}};
        end else begin
            strobe_prev_r <= strobe_s;
            settle_r      <= {settle_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Write / read-back / verify sequencer with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            pointer_r   <= {ADDR_W{1'b0}};
            ram_we      <= 1'b0;
            ram_addr    <= {ADDR_W{1'b0}};
            ram_wdata   <= {DATA_W{1'b0}};
            cpu_halt    <= 1'b0;
            busy        <= 1'b0;
            verify_err  <= 1'b0;
            overrun     <= 1'b0;
            write_count <= {(ADDR_W+1){1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (prog_s) begin
                        state_r     <= ST_ARMED;
                        cpu_halt    <= 1'b1;
                        pointer_r   <= addr_sync_s;
                        write_count <= {(ADDR_W+1){1'b0}};
                        verify_err  <= 1'b0;
                        overrun     <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (strobe_evt_s) begin
                        state_r   <= ST_WRITE;
                        ram_we    <= 1'b1;
                        busy      <= 1'b1;
                        ram_addr  <= auto_s ? pointer_r : addr_sync_s;
                        ram_wdata <= data_sync_s;
                    end else if (!prog_s) begin
                        state_r  <= ST_IDLE;
                        cpu_halt <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    ram_we  <= 1'b0;
                    state_r <= ST_READ;
                    if (strobe_evt_s) overrun <= 1'b1;
                end
                ST_READ: begin
                    state_r <= ST_CHECK;
                    if (strobe_evt_s) overrun <= 1'b1;
                end
                ST_CHECK: begin
                    if (strobe_evt_s) overrun <= 1'b1;
                    if (ram_rdata != ram_wdata) verify_err <= 1'b1;
                    if (write_count != {(ADDR_W+1){1'b1}}) begin
                        write_count <= write_count + (ADDR_W+1)'(1);
                    end
                    if (auto_s) pointer_r <= pointer_r + ADDR_W'(1);
                    busy <= 1'b0;
                    if (prog_s) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r  <= ST_IDLE;
                        cpu_halt <= 1'b0;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ram_we   <= 1'b0;
                    busy     <= 1'b0;
                    cpu_halt <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader with a behavioural RAM and loader model.
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       prog_mode, wr_strobe, auto_inc;
    logic [3:0] addr_in;
    logic [7:0] data_in;
    logic       ram_we;
    logic [3:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    logic       cpu_halt, busy, verify_err, overrun;
    logic [4:0] write_count;

    int n_checks = 0;
    int n_errors = 0;
    int we_cnt   = 0;
    bit fault    = 1'b0;
    logic [7:0] mem [16];

    // model state: session pointer, write count, sticky flags, auto mode
    int m_ptr, m_cnt;
    bit m_verr, m_ovr, m_auto;

    prog_loader #(.DATA_W(8), .ADDR_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .prog_mode(prog_mode), .addr_in(addr_in),
        .data_in(data_in), .wr_strobe(wr_strobe), .auto_inc(auto_inc),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .cpu_halt(cpu_halt), .busy(busy),
        .verify_err(verify_err), .overrun(overrun), .write_count(write_count)
    );

    always #5 clk = ~clk;

    // synchronous RAM, read-before-write, optional stuck-at-zero read data
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= fault ? 8'h00 : mem[ram_addr];
    end

    always @(negedge clk) if (ram_we) we_cnt++;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_we"},    {31'd0, ram_we}, 32'd0);
        check_val({tag, "_addr"},  {28'd0, ram_addr}, 32'd0);
        check_val({tag, "_wdata"}, {24'd0, ram_wdata}, 32'd0);
        check_val({tag, "_flags"}, {28'd0, cpu_halt, busy, verify_err, overrun}, 32'd0);
        check_val({tag, "_count"}, {27'd0, write_count}, 32'd0);
    endtask

    task automatic model_write(input logic [7:0] d, input bit bad);
        if (m_cnt < 31) m_cnt++;
        if (bad && d != 8'h00) m_verr = 1'b1;
        if (m_auto) m_ptr = (m_ptr + 1) % 16;
    endtask

    task automatic session_start(input bit au, input logic [3:0] a);
        auto_inc = au; addr_in = a; wr_strobe = 1'b0;
        repeat (3) @(negedge clk);
        prog_mode = 1'b1;
        repeat (4) @(negedge clk);
        m_auto = au; m_ptr = a; m_cnt = 0; m_verr = 1'b0; m_ovr = 1'b0;
        check_val("start_halt", {31'd0, cpu_halt}, 32'd1);
        check_val("start_busy", {31'd0, busy}, 32'd0);
        check_val("start_flags", {30'd0, verify_err, overrun}, 32'd0);
        check_val("start_count", {27'd0, write_count}, 32'd0);
    endtask

    task automatic session_end();
        prog_mode = 1'b0;
        repeat (5) @(negedge clk);
        check_val("end_halt", {31'd0, cpu_halt}, 32'd0);
    endtask

    // raise strobe and wait (bounded) for the write pulse; returns negedges elapsed
    task automatic strobe_and_wait(output bit found, output int lat);
        found = 1'b0; lat = 0;
        wr_strobe = 1'b1;
        for (int i = 1; i <= 10 && !found; i++) begin
            @(negedge clk);
            if (ram_we) begin found = 1'b1; lat = i; end
        end
        check_val("we_seen", {31'd0, found}, 32'd1);
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d, input bit bad);
        int  base, lat, exp_a;
        bit  found;
        addr_in = a; data_in = d; fault = bad;
        repeat (3) @(negedge clk);
        exp_a = m_auto ? m_ptr : a;
        base = we_cnt;
        strobe_and_wait(found, lat);
        if (found) begin
            check_val("we_latency", lat, 32'd3);
            check_val("we_addr", {28'd0, ram_addr}, exp_a);
            check_val("we_data", {24'd0, ram_wdata}, {24'd0, d});
            @(negedge clk);
            check_val("read_we_low", {31'd0, ram_we}, 32'd0);
            check_val("read_addr_hold", {28'd0, ram_addr}, exp_a);
            @(negedge clk);
            check_val("check_data_hold", {24'd0, ram_wdata}, {24'd0, d});
            check_val("check_busy", {31'd0, busy}, 32'd1);
        end
        wr_strobe = 1'b0;
        repeat (4) @(negedge clk);
        fault = 1'b0;
        model_write(d, bad);
        check_val("single_pulse", we_cnt - base, 32'd1);
        check_val("count", {27'd0, write_count}, m_cnt);
        check_val("verify_err", {31'd0, verify_err}, {31'd0, m_verr});
        check_val("overrun", {31'd0, overrun}, {31'd0, m_ovr});
        check_val("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic overrun_write(input logic [3:0] a, input logic [7:0] d);
        int base;
        addr_in = a; data_in = d;
        repeat (3) @(negedge clk);
        base = we_cnt;
        wr_strobe = 1'b1; @(negedge clk);
        wr_strobe = 1'b0; @(negedge clk);
        wr_strobe = 1'b1;
        repeat (12) @(negedge clk);
        wr_strobe = 1'b0;
        repeat (4) @(negedge clk);
        model_write(d, 1'b0);
        m_ovr = 1'b1;
        check_val("ovr_one_pulse", we_cnt - base, 32'd1);
        check_val("ovr_flag", {31'd0, overrun}, 32'd1);
        check_val("ovr_count", {27'd0, write_count}, m_cnt);
    endtask

    task automatic drop_mid_write(input logic [3:0] a, input logic [7:0] d);
        bit found; int lat;
        addr_in = a; data_in = d;
        repeat (3) @(negedge clk);
        strobe_and_wait(found, lat);
        prog_mode = 1'b0;
        @(negedge clk);
        check_val("drop_read_halt", {31'd0, cpu_halt}, 32'd1);
        @(negedge clk);
        check_val("drop_check_halt", {31'd0, cpu_halt}, 32'd1);
        @(negedge clk);
        check_val("drop_idle_halt", {31'd0, cpu_halt}, 32'd0);
        check_val("drop_idle_busy", {31'd0, busy}, 32'd0);
        wr_strobe = 1'b0;
        model_write(d, 1'b0);
        check_val("drop_count", {27'd0, write_count}, m_cnt);
        check_val("drop_mem", {24'd0, mem[m_auto ? (m_ptr + 15) % 16 : a]}, {24'd0, d});
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rst_n = 1'b0; prog_mode = 1'b0; wr_strobe = 1'b0; auto_inc = 1'b0;
        addr_in = 4'd0; data_in = 8'd0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // single addressed write with good read-back
        session_start(1'b0, 4'd3);
        do_write(4'd3, 8'hA5, 1'b0);
        check_val("mem3", {24'd0, mem[3]}, 32'h0000_00A5);
        session_end();

        // auto-increment wrap 14, 15, 0
        session_start(1'b1, 4'd14);
        do_write(4'd2, 8'h11, 1'b0);
        do_write(4'd9, 8'h22, 1'b0);
        do_write(4'd5, 8'h33, 1'b0);
        check_val("wrap_mem14", {24'd0, mem[14]}, 32'h11);
        check_val("wrap_mem15", {24'd0, mem[15]}, 32'h22);
        check_val("wrap_mem0",  {24'd0, mem[0]},  32'h33);
        session_end();

        // sticky verify error, overrun, prog_mode drop mid-sequence
        session_start(1'b0, 4'd0);
        do_write(4'd7, 8'h5A, 1'b1);
        do_write(4'd8, 8'h3C, 1'b0);
        overrun_write(4'd9, 8'h77);
        drop_mid_write(4'd10, 8'h88);
        check_val("sticky_err_idle", {31'd0, verify_err}, 32'd1);
        session_start(1'b0, 4'd0);
        session_end();

        // randomized sessions
        for (int s = 0; s < 3; s++) begin
            session_start(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            for (int w = 0; w < 5; w++) begin
                do_write(4'($urandom_range(0, 15)), 8'($urandom_range(1, 255)),
                         ($urandom_range(0, 3) == 0));
            end
            session_end();
        end

        // write_count saturation
        session_start(1'b1, 4'($urandom_range(0, 15)));
        for (int w = 0; w < 33; w++) do_write(4'd0, 8'($urandom), 1'b0);
        check_val("saturate", {27'd0, write_count}, 32'd31);

        // reset during READ, strobe held through release
        begin
            bit found; int lat; int base;
            addr_in = 4'd6; data_in = 8'hC3;
            repeat (3) @(negedge clk);
            strobe_and_wait(found, lat);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_outputs_zero("midreset");
            repeat (2) @(negedge clk);
            base = we_cnt;
            rst_n = 1'b1;
            repeat (12) @(negedge clk);
            check_val("no_we_after_rst", we_cnt - base, 32'd0);
            check_val("rearm_halt", {31'd0, cpu_halt}, 32'd1);
            check_val("rearm_count", {27'd0, write_count}, 32'd0);
            wr_strobe = 1'b0;
            repeat (4) @(negedge clk);
            m_auto = 1'b1; m_ptr = 6; m_cnt = 0; m_verr = 1'b0; m_ovr = 1'b0;
            do_write(4'd1, 8'h4E, 1'b0);
            session_end();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DATA_W, default 8: RAM data width.
REQ-002 Parameter ADDR_W, default 4: RAM address width (16 locations).
REQ-003 Parameter SYNC_STAGES, default 2: synchronizer depth for all pin inputs (minimum 2).
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 prog_mode  in  1  asynchronous pin; 1 = programming mode, CPU halted.
REQ-007 addr_in  in  ADDR_W  asynchronous pin; target address, or start address in auto-increment mode.
REQ-008 data_in  in  DATA_W  asynchronous pin; byte to write.
REQ-009 wr_strobe  in  1  asynchronous pin; rising edge requests one write.
REQ-010 auto_inc  in  1  asynchronous pin; 1 = internal address pointer replaces addr_in.
REQ-011 ram_we  out  1  one-cycle RAM write enable.
REQ-012 ram_addr  out  ADDR_W  RAM address for write and read-back.
REQ-013 ram_wdata  out  DATA_W  RAM write data.
REQ-014 ram_rdata  in  DATA_W  RAM read data; synchronous RAM, 1-cycle read latency.
REQ-015 cpu_halt  out  1  high while programming or a write sequence is in flight.
REQ-016 busy  out  1  high in any state other than IDLE and ARMED.
REQ-017 verify_err  out  1  sticky read-back mismatch flag.
REQ-018 overrun  out  1  sticky flag: strobe edge arrived while busy.
REQ-019 write_count  out  ADDR_W+1  writes completed in the current session; saturates at all-ones.

Function
REQ-020 All pin inputs SHALL pass through SYNC_STAGES flops; the FSM uses synchronized values only.
REQ-021 A strobe event SHALL be a synchronized 0->1 transition of wr_strobe, detected with one additional history flop.
REQ-022 The FSM states SHALL be IDLE, ARMED, WRITE, READ, CHECK.
REQ-023 IDLE->ARMED on synchronized prog_mode=1; on that transition: pointer <= addr_in, write_count <= 0, verify_err <= 0, overrun <= 0.
REQ-024 ARMED->WRITE on a strobe event; ARMED->IDLE on prog_mode=0 with no strobe event in the same cycle.
REQ-025 On the ARMED->WRITE transition, ram_addr SHALL latch (auto_inc ? pointer : addr_in) and ram_wdata SHALL latch data_in.
REQ-026 In WRITE, ram_we SHALL be 1 for exactly that one cycle; next state is READ.
REQ-027 In READ, ram_addr SHALL be held with ram_we=0; next state is CHECK.
REQ-028 In CHECK, if ram_rdata != ram_wdata, verify_err SHALL be set; write_count increments (saturating); if auto_inc, pointer increments modulo 2^ADDR_W (15 wraps to 0).
REQ-029 CHECK SHALL go to ARMED if prog_mode=1, otherwise to IDLE.
REQ-030 Strobe-event-to-ram_we latency SHALL be exactly 1 cycle; a full write sequence SHALL occupy 3 cycles.
REQ-031 A strobe event in WRITE, READ or CHECK SHALL be dropped and SHALL set overrun.
REQ-032 prog_mode falling mid-sequence SHALL NOT abort the sequence; it completes, then the FSM returns to IDLE.
REQ-033 cpu_halt SHALL equal (state != IDLE).
REQ-034 ram_addr and ram_wdata SHALL be held stable from WRITE through CHECK.

Reset
REQ-035 When rst_n=0, all flops clear immediately: state=IDLE, all outputs 0, pointer 0, synchronizers and strobe history 0.
REQ-036 Reset mid-sequence SHALL abandon the write with no further ram_we pulse; a strobe held high across reset release SHALL NOT generate an event.

Structure
REQ-037 The FSM state enum and default widths SHALL live in shared package eater_pkg.
REQ-038 The synchronizer SHALL be the reusable sub-module pin_sync, parameterized by width and depth, instantiated once per input group.

Verification
REQ-039 prog_mode=1, addr_in=3, data_in=0xA5, strobe pulse -> single ram_we pulse with ram_addr=3 and ram_wdata=0xA5 one cycle after the synchronized edge; with matching read-back, write_count=1 and verify_err=0.
REQ-040 auto_inc=1, addr_in=14, three strobes -> writes to addresses 14, 15, 0; write_count=3.
REQ-041 Model RAM returns 0x00 for a write of 0x5A -> verify_err=1 and stays 1 until the next IDLE->ARMED entry.
REQ-042 Second strobe edge during READ -> no second ram_we pulse; overrun=1.
REQ-043 prog_mode dropped in the WRITE cycle -> READ and CHECK complete, then IDLE; cpu_halt falls after CHECK.
REQ-044 rst_n asserted during READ -> all outputs 0 immediately; strobe held high through reset release produces no ram_we.
